// File: rtl/sc_fifo_uart_tx_pkg.sv
// sc_fifo_uart_tx_pkg: shared state encoding and parity selectors for the FIFO-fed UART transmitter
package sc_fifo_uart_tx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
endpackage

// File: rtl/sc_fifo_uart_tx_baud_tick.sv
// uart_baud_tick: bit-period counter with synchronous clear and a one-clock terminal-count pulse
module uart_baud_tick #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(BAUD_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(BAUD_DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sc_fifo_uart_tx.sv
// sc_fifo_uart_tx: pops bytes from a show-ahead FIFO and sends each as an async UART frame on txd
module sc_fifo_uart_tx
  import sc_fifo_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV  = 434,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdack,
  input  logic       cts,
  output logic       txd,
  output logic       busy
);
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d, par_q, par_d, txd_q, txd_d, tick;
  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk(clk), .reset_n(reset_n), .clr(init || state_q == ST_IDLE), .tick(tick)
  );
  assign fifo_rdack = reset_n && !init && state_q == ST_IDLE && !fifo_empty && cts;
  assign txd  = txd_q;
  assign busy = state_q != ST_IDLE;
  // txd_d always reflects the level of the bit being entered so txd stays a clean flop output
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    txd_d   = txd_q;
    if (init) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      stop_d  = 1'b0;
      txd_d   = 1'b1;
    end else case (state_q)
      ST_IDLE: if (fifo_rdack) begin
        shift_d = fifo_q;
        par_d   = ^fifo_q ^ (PARITY == PARITY_ODD);
        state_d = ST_START;
        txd_d   = 1'b0;
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        bit_d   = '0;
        txd_d   = shift_q[0];
      end
      ST_DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          state_d = PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
          txd_d   = PARITY != PARITY_NONE ? par_q : 1'b1;
          stop_d  = 1'b0;
        end else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          txd_d   = shift_q[1];
        end
      end
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        stop_d  = 1'b0;
        txd_d   = 1'b1;
      end
      ST_STOP: if (tick) begin
        if (STOP_BITS == 1 || stop_q) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end else stop_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
endmodule

// File: tb/tb_sc_fifo_uart_tx.sv
// tb_sc_fifo_uart_tx: three parity/stop variants fed by show-ahead FIFO models, checked against a frame-level model
`timescale 1ns/1ps
module tb_sc_fifo_uart_tx;
  localparam int B = 4;
  localparam int PAR [3] = '{2, 0, 1};
  localparam int STP [3] = '{1, 1, 2};
  logic clk = 1'b0, reset_n = 1'b0, init = 1'b0, cts = 1'b1;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] rdack, txd, busy;
  logic [7:0] fifo_q [3];
  logic [7:0] mem [3][64];
  int wr [3] = '{0, 0, 0};
  int rd [3] = '{0, 0, 0};
  int ack_cnt [3] = '{0, 0, 0};
  int m_t [3] = '{0, 0, 0};
  logic [11:0] m_bits [3];
  logic [10:0] a5_frame = 11'b1_0_10100101_0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sc_fifo_uart_tx #(.BAUD_DIV(B), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset_n(reset_n), .init(init), .fifo_empty(fifo_empty[0]), .fifo_q(fifo_q[0]),
    .fifo_rdack(rdack[0]), .cts(cts), .txd(txd[0]), .busy(busy[0]));
  sc_fifo_uart_tx #(.BAUD_DIV(B), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .reset_n(reset_n), .init(init), .fifo_empty(fifo_empty[1]), .fifo_q(fifo_q[1]),
    .fifo_rdack(rdack[1]), .cts(cts), .txd(txd[1]), .busy(busy[1]));
  sc_fifo_uart_tx #(.BAUD_DIV(B), .PARITY(1), .STOP_BITS(2)) u_odd2 (
    .clk(clk), .reset_n(reset_n), .init(init), .fifo_empty(fifo_empty[2]), .fifo_q(fifo_q[2]),
    .fifo_rdack(rdack[2]), .cts(cts), .txd(txd[2]), .busy(busy[2]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int flen(input int d);
    return 9 + (PAR[d] != 0 ? 1 : 0) + STP[d];
  endfunction
  function automatic logic [11:0] frame(input int d, input logic [7:0] b);
    logic [11:0] f;
    f = 12'hfff;
    f[8:0] = {b, 1'b0};
    if (PAR[d] != 0) f[9] = PAR[d] == 1 ? ~^b : ^b;
    return f;
  endfunction
  function automatic logic exp_ack(input int d);
    return reset_n && !init && m_t[d] == 0 && !fifo_empty[d] && cts;
  endfunction
  // show-ahead FIFO whose empty/q lag a pop by one clock, as sc_fifo does
  always @(posedge clk)
    for (int d = 0; d < 3; d++) begin
      fifo_empty[d] <= wr[d] == rd[d];
      fifo_q[d] <= mem[d][rd[d] % 64];
      if (rdack[d]) begin
        rd[d] <= rd[d] + 1;
        ack_cnt[d] <= ack_cnt[d] + 1;
      end
    end
  always @(posedge clk or negedge reset_n)
    for (int d = 0; d < 3; d++)
      if (!reset_n || init) m_t[d] <= 0;
      else if (m_t[d] == 0) begin
        if (exp_ack(d)) begin
          m_t[d] <= 1;
          m_bits[d] <= frame(d, fifo_q[d]);
        end
      end else m_t[d] <= m_t[d] == flen(d) * B ? 0 : m_t[d] + 1;
  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("txd%0d", d), txd[d], m_t[d] == 0 ? 1'b1 : m_bits[d][(m_t[d] - 1) / B]);
      chk($sformatf("busy%0d", d), busy[d], m_t[d] != 0);
      chk($sformatf("rdack%0d", d), rdack[d], exp_ack(d));
    end
  task automatic push(input int d, input logic [7:0] b);
    mem[d][wr[d] % 64] = b;
    wr[d]++;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wait_ack(input int d, input int lim, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdack[d] && n < lim);
    chk(nm, rdack[d], 1'b1);
  endtask
  initial begin
    int n, base;
    cyc(3);
    reset_n = 1'b1;
    cyc(100);
    chk("idle_acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2], 0);
    chk("idle_txd", txd, 3'b111);
    chk("idle_busy", busy, 3'b000);
    push(0, 8'hA5);
    wait_ack(0, 10, "a5_pop");
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      chk($sformatf("a5_txd@%0d", i), txd[0], i <= 44 ? a5_frame[(i - 1) / 4] : 1'b1);
      chk($sformatf("a5_busy@%0d", i), busy[0], i <= 44);
    end
    cyc(5);
    push(1, 8'h00);
    push(1, 8'hFF);
    wait_ack(1, 10, "b2b_pop1");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdack[1] && n < 100);
    chk("b2b_spacing", n, 41);
    chk("b2b_idle_txd", txd[1], 1'b1);
    @(negedge clk);
    chk("b2b_start_edge", txd[1], 1'b0);
    cyc(50);
    push(2, 8'h01);
    wait_ack(2, 10, "odd_pop");
    n = 0;
    for (int i = 1; i <= 52; i++) begin
      @(negedge clk);
      n += int'(busy[2]);
      if (i >= 37 && i <= 40) chk($sformatf("odd_parity@%0d", i), txd[2], 1'b0);
      if (i >= 41) chk($sformatf("odd_stop@%0d", i), txd[2], 1'b1);
    end
    chk("odd_frame_len", n, 48);
    cyc(5);
    cts = 1'b0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    base = ack_cnt[0];
    cyc(20);
    chk("cts_hold", ack_cnt[0] - base, 0);
    cts = 1'b1;
    wait_ack(0, 5, "cts_pop1");
    cyc(10);
    cts = 1'b0;
    cyc(60);
    chk("cts_mid_frame", ack_cnt[0] - base, 1);
    chk("cts_frame_done", busy[0], 1'b0);
    cts = 1'b1;
    cyc(100);
    chk("cts_all", ack_cnt[0] - base, 3);
    chk("cts_idle", busy[0], 1'b0);
    chk("cts_drained", fifo_empty[0], 1'b1);
    push(1, 8'h3C);
    push(1, 8'h5A);
    push(1, 8'hC3);
    wait_ack(1, 10, "init_pop");
    cyc(18);
    init = 1'b1;
    @(negedge clk);
    chk("init_no_pop", rdack[1], 1'b0);
    chk("init_busy_before", busy[1], 1'b1);
    cyc(1);
    init = 1'b0;
    @(negedge clk);
    chk("init_txd", txd[1], 1'b1);
    chk("init_busy", busy[1], 1'b0);
    chk("init_repop", rdack[1], 1'b1);
    cyc(18);
    reset_n = 1'b0;
    #1;
    chk("reset_txd", txd[1], 1'b1);
    chk("reset_busy", busy[1], 1'b0);
    chk("reset_no_pop", rdack[1], 1'b0);
    cyc(1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_repop", rdack[1], 1'b1);
    cyc(60);
    chk("final_idle", busy, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
